// File: rtl/rv32_pkg.sv
// Shared RV32I decode constants: opcodes, instruction classes, immediate formats,
// and the decoded-instruction record held by the decode stage.
package rv32_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      KIND_ALU    = 3'd0,
      KIND_LOAD   = 3'd1,
      KIND_STORE  = 3'd2,
      KIND_BRANCH = 3'd3,
      KIND_JAL    = 3'd4,
      KIND_JALR   = 3'd5
   } kind_e;

   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [6:0]  func7;
      logic [2:0]  func3;
      logic [6:0]  op;
      logic [31:0] store_data;
      logic [4:0]  rd;
      logic        rd_we;
      kind_e       kind;
      logic [31:0] pc;
      logic [31:0] link;
      logic        illegal;
   } dec_t;

   // All formats sign-extend from bit 31; U places its 20 bits at 31:12.
   function automatic logic [31:0] gen_imm(input logic [31:0] i, input imm_fmt_e fmt);
      case (fmt)
         IMM_I:   return {{20{i[31]}}, i[31:20]};
         IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
         IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         IMM_U:   return {i[31:12], 12'b0};
         default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      endcase
   endfunction

endpackage

// File: rtl/rv_decode_stage_if.sv
// Fetch-side input, writeback port and execute-side output of the decode stage.
// valid/ready: a transfer happens on a rising edge where valid & ready are both high;
// the sender holds its payload stable while valid is high and ready is low.
interface rv_decode_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [6:0]  out_func7;
   logic [2:0]  out_func3;
   logic [6:0]  out_op;
   logic [31:0] out_store_data;
   logic [4:0]  out_rd;
   logic        out_rd_we;
   logic [2:0]  out_kind;
   logic [31:0] out_pc;
   logic [31:0] out_link;
   logic        out_illegal;

   modport slave (
      input  in_valid, in_instr, in_pc, flush, wb_en, wb_rd, wb_data, out_ready,
      output in_ready, out_valid, out_a, out_b, out_func7, out_func3, out_op,
             out_store_data, out_rd, out_rd_we, out_kind, out_pc, out_link, out_illegal
   );

   modport master (
      output in_valid, in_instr, in_pc, flush, wb_en, wb_rd, wb_data, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_func7, out_func3, out_op,
             out_store_data, out_rd, out_rd_we, out_kind, out_pc, out_link, out_illegal
   );
endinterface

// File: rtl/rv_regfile_2r1w.sv
// 32x32 register file: two asynchronous reads, one write, x0 reads zero,
// and a same-cycle write is forwarded to the read ports.
module rv_regfile_2r1w (
   input  logic        clk,
   input  logic [4:0]  raddr1,
   input  logic [4:0]  raddr2,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata
);
   logic [31:0] mem [32];

   always_ff @(posedge clk) begin
      if (we && waddr != 5'd0) mem[waddr] <= wdata;
   end

   assign rdata1 = (raddr1 == 5'd0) ? 32'd0 :
                   (we && waddr == raddr1) ? wdata : mem[raddr1];
   assign rdata2 = (raddr2 == 5'd0) ? 32'd0 :
                   (we && waddr == raddr2) ? wdata : mem[raddr2];
endmodule

// File: rtl/rv_decode_stage.sv
// RV32I decode / operand-fetch stage: reads rs1/rs2, builds immediates and
// ALU operands, and holds them in an output register behind a valid/ready handshake.
module rv_decode_stage
   import rv32_pkg::*;
#(
   parameter int          XLEN          = 32,
   parameter logic [31:0] RESET_PC_LINK = 32'h0
) (
   input logic               clk,
   input logic               resetn,
   rv_decode_stage_if.slave  bus
);
   logic [6:0]      opcode;
   logic [4:0]      rd;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic            valid;
   logic            capture;
   dec_t            d;
   dec_t            q;

   assign opcode = bus.in_instr[6:0];
   assign rd     = bus.in_instr[11:7];
   assign f3     = bus.in_instr[14:12];
   assign f7     = bus.in_instr[31:25];

   rv_regfile_2r1w u_regfile (
      .clk    (clk),
      .raddr1 (bus.in_instr[19:15]),
      .raddr2 (bus.in_instr[24:20]),
      .rdata1 (rs1_val),
      .rdata2 (rs2_val),
      .we     (bus.wb_en),
      .waddr  (bus.wb_rd),
      .wdata  (bus.wb_data)
   );

   assign bus.in_ready = ~valid | bus.out_ready;
   assign capture      = bus.in_valid & bus.in_ready & ~bus.flush;

   always_comb begin
      d            = '0;
      d.op         = OPC_OP_IMM;
      d.kind       = KIND_ALU;
      d.rd         = rd;
      d.store_data = rs2_val;
      d.pc         = bus.in_pc;
      d.link       = bus.in_pc + 32'd4;
      case (opcode)
         OPC_OP: begin
            d.a = rs1_val; d.b = rs2_val;
            d.func7 = f7; d.func3 = f3; d.op = opcode; d.rd_we = 1'b1;
         end
         OPC_OP_IMM: begin
            d.a = rs1_val; d.b = gen_imm(bus.in_instr, IMM_I);
            d.func3 = f3; d.rd_we = 1'b1;
            // Only shifts carry a meaningful func7 (SRAI vs SRLI).
            if (f3 == 3'b001 || f3 == 3'b101) d.func7 = f7;
         end
         OPC_LOAD: begin
            d.a = rs1_val; d.b = gen_imm(bus.in_instr, IMM_I);
            d.rd_we = 1'b1; d.kind = KIND_LOAD;
         end
         OPC_STORE: begin
            d.a = rs1_val; d.b = gen_imm(bus.in_instr, IMM_S); d.kind = KIND_STORE;
         end
         OPC_BRANCH: begin
            // Branches compare by having the ALU subtract rs1 - rs2.
            d.a = rs1_val; d.b = rs2_val;
            d.func7 = 7'b0100000; d.func3 = f3; d.op = OPC_OP; d.kind = KIND_BRANCH;
         end
         OPC_JAL: begin
            d.a = bus.in_pc; d.b = gen_imm(bus.in_instr, IMM_J);
            d.rd_we = 1'b1; d.kind = KIND_JAL;
         end
         OPC_JALR: begin
            d.a = rs1_val; d.b = gen_imm(bus.in_instr, IMM_I);
            d.rd_we = 1'b1; d.kind = KIND_JALR;
         end
         OPC_LUI: begin
            d.b = gen_imm(bus.in_instr, IMM_U); d.rd_we = 1'b1;
         end
         OPC_AUIPC: begin
            d.a = bus.in_pc; d.b = gen_imm(bus.in_instr, IMM_U); d.rd_we = 1'b1;
         end
         default: d.illegal = 1'b1;
      endcase
      if (rd == 5'd0) d.rd_we = 1'b0;
   end

   // Flush wins over capture; a consume without a new capture empties the stage.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid  <= 1'b0;
         q      <= '0;
         q.pc   <= RESET_PC_LINK;
         q.link <= RESET_PC_LINK;
      end else if (bus.flush) begin
         valid <= 1'b0;
      end else if (capture) begin
         valid <= 1'b1;
         q     <= d;
      end else if (bus.out_ready) begin
         valid <= 1'b0;
      end
   end

   assign bus.out_valid      = valid;
   assign bus.out_a          = q.a;
   assign bus.out_b          = q.b;
   assign bus.out_func7      = q.func7;
   assign bus.out_func3      = q.func3;
   assign bus.out_op         = q.op;
   assign bus.out_store_data = q.store_data;
   assign bus.out_rd         = q.rd;
   assign bus.out_rd_we      = q.rd_we;
   assign bus.out_kind       = q.kind;
   assign bus.out_pc         = q.pc;
   assign bus.out_link       = q.link;
   assign bus.out_illegal    = q.illegal;
endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: expected decodes are queued when an
// instruction is offered and compared when it appears on the output.
module tb_rv_decode_stage;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] b_mask;
      logic [31:0] sd;
      logic [31:0] pc;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [6:0]  op;
      logic [2:0]  kind;
      logic [4:0]  rd;
      logic        we;
      logic        ill;
   } exp_t;

   logic clk = 1'b0;
   logic resetn = 1'b1;
   int   checks = 0;
   int   failures = 0;
   exp_t exp_q[$];

   rv_decode_stage_if bus();

   rv_decode_stage #(.XLEN(32), .RESET_PC_LINK(32'h0)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.in_valid  = 1'b0;
      bus.in_instr  = 32'h0;
      bus.in_pc     = 32'h0;
      bus.flush     = 1'b0;
      bus.wb_en     = 1'b0;
      bus.wb_rd     = 5'd0;
      bus.wb_data   = 32'h0;
      bus.out_ready = 1'b1;
   endtask

   task automatic wb(input logic [4:0] r, input logic [31:0] v);
      bus.wb_en = 1'b1; bus.wb_rd = r; bus.wb_data = v;
      step();
      bus.wb_en = 1'b0;
   endtask

   task automatic cap(input logic [31:0] instr, input logic [31:0] pc);
      bus.in_valid = 1'b1; bus.in_instr = instr; bus.in_pc = pc;
      step();
      bus.in_valid = 1'b0;
   endtask

   function automatic void push_exp(input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] b_mask, input logic [31:0] sd,
                                    input logic [31:0] pc, input logic [6:0] f7,
                                    input logic [2:0] f3, input logic [6:0] op,
                                    input logic [2:0] kind, input logic [4:0] rd,
                                    input logic we, input logic ill);
      exp_t e;
      e.a = a; e.b = b; e.b_mask = b_mask; e.sd = sd; e.pc = pc; e.f7 = f7; e.f3 = f3;
      e.op = op; e.kind = kind; e.rd = rd; e.we = we; e.ill = ill;
      exp_q.push_back(e);
   endfunction

   task automatic check_out(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL %s_queue observed=empty expected=entry", tag);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_valid"}, bus.out_valid, 1);
         chk({tag, "_a"}, bus.out_a, e.a);
         chk({tag, "_b"}, bus.out_b & e.b_mask, e.b & e.b_mask);
         chk({tag, "_func7"}, bus.out_func7, e.f7);
         chk({tag, "_func3"}, bus.out_func3, e.f3);
         chk({tag, "_op"}, bus.out_op, e.op);
         chk({tag, "_kind"}, bus.out_kind, e.kind);
         chk({tag, "_rd_we"}, bus.out_rd_we, e.we);
         chk({tag, "_illegal"}, bus.out_illegal, e.ill);
         chk({tag, "_pc"}, bus.out_pc, e.pc);
         chk({tag, "_link"}, bus.out_link, e.pc + 32'd4);
         if (e.we) chk({tag, "_rd"}, bus.out_rd, e.rd);
         if (e.kind == 3'd2) chk({tag, "_store_data"}, bus.out_store_data, e.sd);
      end
   endtask

   initial begin
      logic [4:0]  r1, r2;
      logic [31:0] v1, v2;

      idle();
      #2 resetn = 1'b0;
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_a", bus.out_a, 0);
      chk("rst_out_b", bus.out_b, 0);
      chk("rst_out_pc", bus.out_pc, 0);
      chk("rst_out_link", bus.out_link, 0);
      chk("rst_out_rd_we", bus.out_rd_we, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;

      // ADD x7,x5,x5 after writing x5
      wb(5'd5, 32'h0000_0010);
      wb(5'd2, 32'h8000_0000);
      wb(5'd1, 32'h0000_0005);
      push_exp(32'h10, 32'h10, '1, 0, 32'h40, 7'h00, 3'd0, 7'h33, 3'd0, 5'd7, 1'b1, 1'b0);
      cap(32'h005283B3, 32'h40);
      check_out("add");
      step();
      chk("drain_valid", bus.out_valid, 0);

      // SRAI then ADDI back to back; b of a shift is checked on the shamt bits
      push_exp(32'h8000_0000, 32'h3, 32'h1F, 0, 32'h80, 7'h20, 3'd5, 7'h13, 3'd0, 5'd1, 1'b1, 1'b0);
      cap(32'h40315093, 32'h80);
      check_out("srai");
      push_exp(32'h8000_0000, 32'hFFFF_FFFF, '1, 0, 32'h84, 7'h00, 3'd0, 7'h13, 3'd0, 5'd1, 1'b1, 1'b0);
      cap(32'hFFF10093, 32'h84);
      check_out("addi_neg");

      // BEQ x1,x2,+8 at 0x100
      push_exp(32'h5, 32'h8000_0000, '1, 0, 32'h100, 7'h20, 3'd0, 7'h33, 3'd3, 5'd0, 1'b0, 1'b0);
      cap(32'h00208463, 32'h100);
      check_out("beq");
      // SW x2,12(x1)
      push_exp(32'h5, 32'd12, '1, 32'h8000_0000, 32'h104, 7'h00, 3'd0, 7'h13, 3'd2, 5'd0, 1'b0, 1'b0);
      cap(32'h0020A623, 32'h104);
      check_out("sw");
      // JAL x1,+16 at 0x300
      push_exp(32'h300, 32'd16, '1, 0, 32'h300, 7'h00, 3'd0, 7'h13, 3'd4, 5'd1, 1'b1, 1'b0);
      cap(32'h010000EF, 32'h300);
      check_out("jal");
      // ADDI x0,x0,1: destination x0 is never written
      push_exp(32'h0, 32'h1, '1, 0, 32'h304, 7'h00, 3'd0, 7'h13, 3'd0, 5'd0, 1'b0, 1'b0);
      cap(32'h00100013, 32'h304);
      check_out("addi_x0");
      // custom-0 opcode is illegal
      push_exp(32'h0, 32'h0, '1, 0, 32'h308, 7'h00, 3'd0, 7'h13, 3'd0, 5'd0, 1'b0, 1'b1);
      cap(32'h0000000B, 32'h308);
      check_out("illegal");

      // Stall: LUI held while AUIPC waits
      push_exp(32'h0, 32'h1234_5000, '1, 0, 32'h180, 7'h00, 3'd0, 7'h13, 3'd0, 5'd4, 1'b1, 1'b0);
      cap(32'h12345237, 32'h180);
      check_out("lui");
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_instr = 32'h00001317; bus.in_pc = 32'h200;
      push_exp(32'h200, 32'h1000, '1, 0, 32'h200, 7'h00, 3'd0, 7'h13, 3'd0, 5'd6, 1'b1, 1'b0);
      #1;
      chk("stall_in_ready0", bus.in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_valid", bus.out_valid, 1);
         chk("stall_b", bus.out_b, 32'h1234_5000);
         chk("stall_pc", bus.out_pc, 32'h180);
         chk("stall_in_ready", bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      check_out("auipc_b2b");

      // Writeback in the capture cycle is forwarded
      bus.wb_en = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'hDEAD_BEEF;
      push_exp(32'hDEAD_BEEF, 32'h0, '1, 0, 32'h400, 7'h00, 3'd0, 7'h33, 3'd0, 5'd8, 1'b1, 1'b0);
      cap(32'h00018433, 32'h400);
      bus.wb_en = 1'b0;
      check_out("bypass");
      bus.wb_en = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hFFFF_FFFF;
      push_exp(32'h0, 32'h5, '1, 0, 32'h404, 7'h00, 3'd0, 7'h13, 3'd0, 5'd9, 1'b1, 1'b0);
      cap(32'h00500493, 32'h404);
      bus.wb_en = 1'b0;
      check_out("x0_bypass");
      push_exp(32'h0, 32'hDEAD_BEEF, '1, 0, 32'h408, 7'h00, 3'd0, 7'h33, 3'd0, 5'd10, 1'b1, 1'b0);
      cap(32'h00300533, 32'h408);
      check_out("x0_read");

      // Random register values through ADD x21,rA,rB
      for (int i = 0; i < 4; i++) begin
         r1 = 5'($urandom_range(11, 20));
         r2 = 5'($urandom_range(11, 20));
         v1 = $urandom;
         v2 = $urandom;
         wb(r1, v1);
         wb(r2, v2);
         push_exp((r1 == r2) ? v2 : v1, v2, '1, 0, 32'h500, 7'h00, 3'd0, 7'h33, 3'd0,
                  5'd21, 1'b1, 1'b0);
         cap({7'b0, r2, r1, 3'b000, 5'd21, 7'b0110011}, 32'h500);
         check_out("rand_add");
      end

      // Flush beats a capture in the same cycle
      bus.flush = 1'b1;
      cap(32'h005283B3, 32'h600);
      bus.flush = 1'b0;
      chk("flush_valid", bus.out_valid, 0);
      step();
      chk("flush_dropped", bus.out_valid, 0);

      // Flush clears a stalled output
      push_exp(32'h0, 32'h1234_5000, '1, 0, 32'h610, 7'h00, 3'd0, 7'h13, 3'd0, 5'd4, 1'b1, 1'b0);
      cap(32'h12345237, 32'h610);
      check_out("lui2");
      bus.out_ready = 1'b0;
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      chk("flush_held_valid", bus.out_valid, 0);
      bus.out_ready = 1'b1;

      // Asynchronous reset during a stall
      push_exp(32'h340, 32'd16, '1, 0, 32'h340, 7'h00, 3'd0, 7'h13, 3'd4, 5'd1, 1'b1, 1'b0);
      cap(32'h010000EF, 32'h340);
      check_out("jal2");
      bus.out_ready = 1'b0;
      step();
      step();
      chk("pre_reset_valid", bus.out_valid, 1);
      #2 resetn = 1'b0;
      #1;
      chk("async_rst_valid", bus.out_valid, 0);
      chk("async_rst_a", bus.out_a, 0);
      chk("async_rst_b", bus.out_b, 0);
      chk("async_rst_pc", bus.out_pc, 0);
      chk("async_rst_link", bus.out_link, 0);
      chk("async_rst_kind", bus.out_kind, 0);
      chk("async_rst_rd_we", bus.out_rd_we, 0);
      chk("queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
